// File: rtl/relu_grad_pkg.sv
// Shared CNN definitions for the ReLU forward/backward pair.
// Holds the default word width and the sign-to-mask helper so the forward
// ReLU and its gradient gate agree that a zero activation counts as "pass".
package relu_grad_pkg;

   localparam int NUM_WIDTH_DEF  = 16;
   localparam int MASK_DEPTH_DEF = 1024;
   localparam int STATS_W        = 32;

   // A non-negative activation (sign bit clear, including zero) lets the gradient through.
   function automatic logic sign_to_pass(input logic sign_bit);
      return ~sign_bit;
   endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// One-bit-wide synchronous FIFO holding the forward ReLU pass/block mask.
// Count is registered; the head bit is read combinationally so the gate
// can use it in the same cycle the gradient is accepted.
module relu_mask_fifo #(
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push_i,
   input  logic        wr_bit_i,
   input  logic        pop_i,
   output logic        rd_bit_o,
   output logic [AW:0] count_o
);

   logic [DEPTH-1:0] mem_q;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q,  count_d;

   // Advance pointers on push/pop; power-of-two depth makes them wrap for free.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers, cleared by synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Mask storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wr_bit_i;
   end

   assign rd_bit_o = mem_q[rd_ptr_q];
   assign count_o  = count_q;

endmodule

// File: rtl/relu_grad.sv
// Backward-pass ReLU gate: records forward activation signs in a bit FIFO and
// zeroes returning gradients whose forward value was negative.
// Optional statistics (zero_count_o / stats_clr_i) are enabled by defining
// RELU_GRAD_STATS_EN.
module relu_grad
   import relu_grad_pkg::*;
#(
   parameter  int NUM_WIDTH  = NUM_WIDTH_DEF,
   parameter  int MASK_DEPTH = MASK_DEPTH_DEF,
   localparam int MASK_AW    = $clog2(MASK_DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 bypass_i,
   input  logic                 fwd_valid_i,
   output logic                 fwd_ready_o,
   input  logic [NUM_WIDTH-1:0] fwd_data_i,
   input  logic                 grad_valid_i,
   output logic                 grad_ready_o,
   input  logic [NUM_WIDTH-1:0] grad_data_i,
   output logic                 dn_valid_o,
   input  logic                 dn_ready_i,
   output logic [NUM_WIDTH-1:0] dn_data_o,
`ifdef RELU_GRAD_STATS_EN
   output logic [STATS_W-1:0]   zero_count_o,
   input  logic                 stats_clr_i,
`endif
   output logic [MASK_AW:0]     mask_count_o
);

   localparam logic [MASK_AW:0] FULL_COUNT = (MASK_AW + 1)'(MASK_DEPTH);

   logic                 mask_bit;
   logic [MASK_AW:0]     mask_count;
   logic                 ofree;
   logic                 accept;
   logic                 push;
   logic                 pop;
   logic                 dn_valid_q, dn_valid_d;
   logic [NUM_WIDTH-1:0] dn_data_q,  dn_data_d;

   relu_mask_fifo #(
      .DEPTH (MASK_DEPTH)
   ) u_mask_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_i   (push),
      .wr_bit_i (sign_to_pass(fwd_data_i[NUM_WIDTH-1])),
      .pop_i    (pop),
      .rd_bit_o (mask_bit),
      .count_o  (mask_count)
   );

   // Handshake: forward side stalls only on a full mask FIFO; the gradient side
   // waits for a free output slot and a mask that was written in an earlier cycle.
   always_comb begin
      ofree        = ~dn_valid_q | dn_ready_i;
      fwd_ready_o  = bypass_i | (mask_count != FULL_COUNT);
      grad_ready_o = ofree & (bypass_i | (mask_count != '0));
      accept       = grad_valid_i & grad_ready_o;
      push         = fwd_valid_i & fwd_ready_o & ~bypass_i;
      pop          = accept & ~bypass_i;
   end

   // Output slot: load the gated gradient on accept, hold while stalled, drain on ready.
   always_comb begin
      dn_valid_d = dn_valid_q;
      dn_data_d  = dn_data_q;
      if (accept) begin
         dn_valid_d = 1'b1;
         dn_data_d  = (bypass_i | mask_bit) ? grad_data_i : '0;
      end else if (dn_ready_i) begin
         dn_valid_d = 1'b0;
      end
   end

   // Output register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dn_valid_q <= 1'b0;
         dn_data_q  <= '0;
      end else begin
         dn_valid_q <= dn_valid_d;
         dn_data_q  <= dn_data_d;
      end
   end

   assign dn_valid_o   = dn_valid_q;
   assign dn_data_o    = dn_data_q;
   assign mask_count_o = mask_count;

`ifdef RELU_GRAD_STATS_EN
   logic               zero_event;
   logic [STATS_W-1:0] zero_count_q, zero_count_d;

   // Count gradients that were nonzero but blocked by the mask; clear wins, saturate at all-ones.
   always_comb begin
      zero_event   = pop & ~mask_bit & (grad_data_i != '0);
      zero_count_d = zero_count_q;
      if (stats_clr_i) begin
         zero_count_d = '0;
      end else if (zero_event && (zero_count_q != '1)) begin
         zero_count_d = zero_count_q + 1'b1;
      end
   end

   // Statistics register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         zero_count_q <= '0;
      end else begin
         zero_count_q <= zero_count_d;
      end
   end

   assign zero_count_o = zero_count_q;
`endif

endmodule
